// File: rtl/wm_mole_sequencer_if.sv
// Player-side bundle of the whack-a-mole round engine: game controls, buttons, LED drive and score.
// master = controller/test side, slave = the sequencer.
interface wm_mole_sequencer_if #(
    parameter int N_MOLES = 4,
    parameter int IDX_W   = 2,
    parameter int TIME_W  = 16,
    parameter int SCORE_W = 8
);
    logic               enable;
    logic               clear;
    logic [IDX_W-1:0]   rn;
    logic [TIME_W-1:0]  on_time;
    logic [TIME_W-1:0]  gap_time;
    logic [N_MOLES-1:0] btn;
    logic [N_MOLES-1:0] mole;
    logic               hit;
    logic               miss;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] misses;
    logic               active;

    modport master (
        output enable, clear, rn, on_time, gap_time, btn,
        input  mole, hit, miss, score, misses, active
    );

    modport slave (
        input  enable, clear, rn, on_time, gap_time, btn,
        output mole, hit, miss, score, misses, active
    );
endinterface

// File: rtl/wm_mole_sequencer.sv
// Whack-a-mole round engine: dark gap, one random mole lit for on_time+1 cycles, hit/miss judged from buttons.
// Latency: all outputs registered; a correct button is reflected (hit, score, mole off) one edge later.
// Backpressure: none; inputs are sampled every cycle and out-of-range rn simply stretches the gap.
module wm_mole_sequencer #(
    parameter int N_MOLES = 4,
    parameter int IDX_W   = 2,
    parameter int TIME_W  = 16,
    parameter int SCORE_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    wm_mole_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, GAP, SHOW} state_t;

    localparam logic [IDX_W:0]     MOLE_LIM = (IDX_W + 1)'(N_MOLES);
    localparam logic [N_MOLES-1:0] MOLE_ONE = N_MOLES'(1);

    state_t             state, state_nxt;
    logic [TIME_W-1:0]  timer, timer_nxt;
    logic [N_MOLES-1:0] mole_q, mole_nxt;
    logic               hit_q, hit_nxt;
    logic               miss_q, miss_nxt;
    logic [SCORE_W-1:0] score_q, score_nxt;
    logic [SCORE_W-1:0] misses_q, misses_nxt;
    logic               active_q;
    logic               rn_ok;
    logic               struck;

    // Out-of-range indices are rejected rather than folded, so every mole stays equally likely.
    assign rn_ok  = {1'b0, bus.rn} < MOLE_LIM;
    assign struck = |(bus.btn & mole_q);

    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        mole_nxt   = mole_q;
        hit_nxt    = 1'b0;
        miss_nxt   = 1'b0;
        score_nxt  = score_q;
        misses_nxt = misses_q;

        if (!bus.enable) begin
            state_nxt = IDLE;
            timer_nxt = '0;
            mole_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = GAP;
                    timer_nxt = bus.gap_time;
                    mole_nxt  = '0;
                end
                GAP: begin
                    if (timer != '0) begin
                        timer_nxt = timer - TIME_W'(1);
                    end else if (rn_ok) begin
                        state_nxt = SHOW;
                        mole_nxt  = MOLE_ONE << bus.rn;
                        timer_nxt = bus.on_time;
                    end
                end
                SHOW: begin
                    // A hit on the final lit cycle beats the timeout.
                    if (struck) begin
                        hit_nxt   = 1'b1;
                        score_nxt = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
                        mole_nxt  = '0;
                        state_nxt = GAP;
                        timer_nxt = bus.gap_time;
                    end else if (timer == '0) begin
                        miss_nxt   = 1'b1;
                        misses_nxt = (misses_q == '1) ? misses_q : misses_q + SCORE_W'(1);
                        mole_nxt   = '0;
                        state_nxt  = GAP;
                        timer_nxt  = bus.gap_time;
                    end else begin
                        timer_nxt = timer - TIME_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                    mole_nxt  = '0;
                end
            endcase
        end

        if (bus.clear) begin
            score_nxt  = '0;
            misses_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            timer    <= '0;
            mole_q   <= '0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            score_q  <= '0;
            misses_q <= '0;
            active_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            mole_q   <= mole_nxt;
            hit_q    <= hit_nxt;
            miss_q   <= miss_nxt;
            score_q  <= score_nxt;
            misses_q <= misses_nxt;
            active_q <= (state_nxt != IDLE);
        end
    end

    assign bus.mole   = mole_q;
    assign bus.hit    = hit_q;
    assign bus.miss   = miss_q;
    assign bus.score  = score_q;
    assign bus.misses = misses_q;
    assign bus.active = active_q;
endmodule

// File: tb/tb_wm_mole_sequencer.sv
// Bench for wm_mole_sequencer: a 4-mole/8-bit-score and a 3-mole/2-bit-score instance share stimulus
// and are compared every cycle against a round-level model, plus directed checks at key edges.
module tb_wm_mole_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        en, clr;
    logic [1:0]  rn_v;
    logic [15:0] on_v, gap_v;
    logic [3:0]  btn4;
    logic [2:0]  btn3;

    int total = 0;
    int bad   = 0;

    wm_mole_sequencer_if #(.N_MOLES(4), .IDX_W(2), .TIME_W(16), .SCORE_W(8)) b4 ();
    wm_mole_sequencer_if #(.N_MOLES(3), .IDX_W(2), .TIME_W(16), .SCORE_W(2)) b3 ();

    assign b4.enable = en;    assign b3.enable = en;
    assign b4.clear = clr;    assign b3.clear = clr;
    assign b4.rn = rn_v;      assign b3.rn = rn_v;
    assign b4.on_time = on_v; assign b3.on_time = on_v;
    assign b4.gap_time = gap_v; assign b3.gap_time = gap_v;
    assign b4.btn = btn4;     assign b3.btn = btn3;

    wm_mole_sequencer #(.N_MOLES(4), .IDX_W(2), .TIME_W(16), .SCORE_W(8)) u4 (
        .clk(clk), .reset(reset), .bus(b4));
    wm_mole_sequencer #(.N_MOLES(3), .IDX_W(2), .TIME_W(16), .SCORE_W(2)) u3 (
        .clk(clk), .reset(reset), .bus(b3));

    // Round-level model: running flag, lit mole index (-1 = dark), cycles left in current phase.
    int nm[2]   = '{4, 3};
    int smax[2] = '{255, 3};
    int run_m[2], lit_m[2], cnt_m[2], sc_m[2], ms_m[2], hit_m[2], miss_m[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            run_m[k] = 0; lit_m[k] = -1; cnt_m[k] = 0;
            sc_m[k] = 0; ms_m[k] = 0; hit_m[k] = 0; miss_m[k] = 0;
        end
    endtask

    task automatic model_edge(input int k, input logic [3:0] bt);
        hit_m[k] = 0;
        miss_m[k] = 0;
        if (!en) begin
            run_m[k] = 0;
            lit_m[k] = -1;
        end else if (run_m[k] == 0) begin
            run_m[k] = 1;
            cnt_m[k] = int'(gap_v);
        end else if (lit_m[k] < 0) begin
            if (cnt_m[k] > 0) cnt_m[k]--;
            else if (int'(rn_v) < nm[k]) begin
                lit_m[k] = int'(rn_v);
                cnt_m[k] = int'(on_v);
            end
        end else if (bt[lit_m[k]]) begin
            hit_m[k] = 1;
            if (sc_m[k] < smax[k]) sc_m[k]++;
            lit_m[k] = -1;
            cnt_m[k] = int'(gap_v);
        end else if (cnt_m[k] == 0) begin
            miss_m[k] = 1;
            if (ms_m[k] < smax[k]) ms_m[k]++;
            lit_m[k] = -1;
            cnt_m[k] = int'(gap_v);
        end else begin
            cnt_m[k]--;
        end
        if (clr) begin
            sc_m[k] = 0;
            ms_m[k] = 0;
        end
    endtask

    function automatic logic [31:0] exp_mole(input int k);
        return (lit_m[k] < 0) ? 32'd0 : (32'd1 << lit_m[k]);
    endfunction

    function automatic logic [31:0] obs_mole(input int k);
        return (k == 0) ? 32'(b4.mole) : 32'(b3.mole);
    endfunction
    function automatic logic [31:0] obs_hit(input int k);
        return (k == 0) ? 32'(b4.hit) : 32'(b3.hit);
    endfunction
    function automatic logic [31:0] obs_miss(input int k);
        return (k == 0) ? 32'(b4.miss) : 32'(b3.miss);
    endfunction
    function automatic logic [31:0] obs_score(input int k);
        return (k == 0) ? 32'(b4.score) : 32'(b3.score);
    endfunction
    function automatic logic [31:0] obs_misses(input int k);
        return (k == 0) ? 32'(b4.misses) : 32'(b3.misses);
    endfunction
    function automatic logic [31:0] obs_active(input int k);
        return (k == 0) ? 32'(b4.active) : 32'(b3.active);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("m%0d.mole", nm[k]),   obs_mole(k),   exp_mole(k));
            chk($sformatf("m%0d.hit", nm[k]),    obs_hit(k),    32'(hit_m[k]));
            chk($sformatf("m%0d.miss", nm[k]),   obs_miss(k),   32'(miss_m[k]));
            chk($sformatf("m%0d.score", nm[k]),  obs_score(k),  32'(sc_m[k]));
            chk($sformatf("m%0d.misses", nm[k]), obs_misses(k), 32'(ms_m[k]));
            chk($sformatf("m%0d.active", nm[k]), obs_active(k), 32'(run_m[k]));
        end
    endtask

    task automatic step();
        model_edge(0, btn4);
        model_edge(1, {1'b0, btn3});
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic wait_lit(input int k, input int limit);
        int n = 0;
        while (lit_m[k] < 0 && n < limit) begin
            step();
            n++;
        end
        chk($sformatf("wait_lit%0d", nm[k]), 32'(obs_mole(k) != 0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sat_tab[5] = '{1, 2, 3, 3, 3};
        en = 0; clr = 0; rn_v = 0; on_v = 0; gap_v = 0; btn4 = 0; btn3 = 0;
        reset = 1'b0;
        model_reset();
        #12;
        check_all();
        reset = 1'b1;
        step();
        chk("idle_active", 32'(b4.active), 32'd0);

        // Edge-numbered directed round sequence; edge 0 is the first edge with enable high.
        gap_v = 16'd3; on_v = 16'd5; rn_v = 2'd2; en = 1'b1;
        for (int e = 0; e <= 44; e++) begin
            if (e == 16 || e == 36) begin btn4 = 4'b0100; btn3 = 3'b100; end
            if (e == 21)            begin btn4 = 4'b0001; btn3 = 3'b001; end
            if (e == 37) rn_v = 2'd3;
            if (e == 44) rn_v = 2'd1;
            step();
            btn4 = 0; btn3 = 0;
            case (e)
                0:  chk("e0.active", 32'(b4.active), 32'd1);
                3:  chk("e3.mole", 32'(b4.mole), 32'd0);
                4:  begin chk("e4.mole4", 32'(b4.mole), 32'h4); chk("e4.mole3", 32'(b3.mole), 32'h4); end
                9:  chk("e9.miss", 32'(b4.miss), 32'd0);
                10: begin chk("e10.miss", 32'(b4.miss), 32'd1); chk("e10.misses", 32'(b4.misses), 32'd1);
                          chk("e10.mole", 32'(b4.mole), 32'd0); end
                16: begin chk("e16.hit", 32'(b4.hit), 32'd1); chk("e16.score", 32'(b4.score), 32'd1);
                          chk("e16.mole", 32'(b4.mole), 32'd0); end
                19: chk("e19.mole", 32'(b4.mole), 32'd0);
                20: chk("e20.mole", 32'(b4.mole), 32'h4);
                26: begin chk("e26.hit", 32'(b4.hit), 32'd0); chk("e26.miss", 32'(b4.miss), 32'd1);
                          chk("e26.score", 32'(b4.score), 32'd1); chk("e26.misses", 32'(b4.misses), 32'd2); end
                36: begin chk("e36.hit", 32'(b4.hit), 32'd1); chk("e36.miss", 32'(b4.miss), 32'd0);
                          chk("e36.score", 32'(b4.score), 32'd2); end
                40: chk("e40.mole4", 32'(b4.mole), 32'h8);
                43: chk("e43.mole3", 32'(b3.mole), 32'd0);
                44: chk("e44.mole3", 32'(b3.mole), 32'h2);
                default: ;
            endcase
        end

        // Saturation on the 2-bit-score instance.
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clear.score3", 32'(b3.score), 32'd0);
        gap_v = 16'd0; on_v = 16'd3;
        for (int i = 0; i < 5; i++) begin
            rn_v = 2'($urandom_range(0, 2));
            wait_lit(1, 30);
            btn3 = 3'(exp_mole(1));
            btn4 = 4'(exp_mole(0));
            step();
            btn3 = 0; btn4 = 0;
            chk($sformatf("sat%0d.hit", i), 32'(b3.hit), 32'd1);
            chk($sformatf("sat%0d.score", i), 32'(b3.score), 32'(sat_tab[i]));
        end
        wait_lit(1, 30);
        btn3 = 3'(exp_mole(1));
        clr = 1'b1;
        step();
        clr = 1'b0; btn3 = 0;
        chk("clrhit.hit", 32'(b3.hit), 32'd1);
        chk("clrhit.score", 32'(b3.score), 32'd0);

        // Random play against the model.
        for (int i = 0; i < 400; i++) begin
            en    = ($urandom_range(0, 19) != 0);
            clr   = ($urandom_range(0, 49) == 0);
            rn_v  = 2'($urandom);
            on_v  = 16'($urandom_range(0, 4));
            gap_v = 16'($urandom_range(0, 3));
            if (lit_m[0] >= 0 && $urandom_range(0, 2) == 0)
                btn4 = 4'(exp_mole(0)) | 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            else
                btn4 = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            if (lit_m[1] >= 0 && $urandom_range(0, 2) == 0)
                btn3 = 3'(exp_mole(1));
            else
                btn3 = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
            step();
        end
        en = 1'b1; clr = 1'b0; btn4 = 0; btn3 = 0;

        // Enable dropped mid-SHOW.
        on_v = 16'd6; gap_v = 16'd1; rn_v = 2'd1;
        wait_lit(0, 30);
        step();
        en = 1'b0;
        step();
        chk("dis.mole", 32'(b4.mole), 32'd0);
        chk("dis.hit", 32'(b4.hit), 32'd0);
        chk("dis.miss", 32'(b4.miss), 32'd0);
        chk("dis.active", 32'(b4.active), 32'd0);
        en = 1'b1;

        // Asynchronous reset mid-SHOW.
        wait_lit(0, 30);
        reset = 1'b0;
        #2;
        model_reset();
        check_all();
        chk("rst.score", 32'(b4.score), 32'd0);
        #2;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wm_mole_sequencer.md
# wm_mole_sequencer

Parametrised whack-a-mole round engine; the next generation of the single-cycle mole lighter. Instead of decoding a random index straight to LEDs every clock, it runs timed rounds: a gap with all moles dark, one mole lit for a programmable on-time, then hit/miss judgement from player buttons with saturating score and miss counters. It sits between the LFSR random source, the debounced button block and the LED/seven-segment score display.

## Interface

- N_MOLES, 4: number of moles/LEDs/buttons (2..16).
- IDX_W, 2: width of random index; 2**IDX_W >= N_MOLES required.
- TIME_W, 16: width of on/gap time counters.
- SCORE_W, 8: width of score and miss counters.

- clk  in  1  system clock; one clock domain, all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset (reset == 0 resets).
- enable  in  1  game running; low forces IDLE.
- clear  in  1  single-cycle pulse; zeroes score and misses.
- rn  in  IDX_W  random index from LFSR, sampled only at mole launch.
- on_time  in  TIME_W  mole lit duration, in cycles minus one.
- gap_time  in  TIME_W  dark gap duration, in cycles minus one.
- btn  in  N_MOLES  debounced, single-cycle-pulse buttons, bit i = mole i.
- mole  out  N_MOLES  registered one-hot (or zero) LED drive.
- hit  out  1  one-cycle pulse: correct button during SHOW.
- miss  out  1  one-cycle pulse: mole timed out unhit.
- score  out  SCORE_W  hits, saturating.
- misses  out  SCORE_W  timeouts, saturating.
- active  out  1  high in GAP or SHOW.

## Operation

- States: IDLE, GAP, SHOW. Internal down-counter timer (TIME_W).
- Reset (async, reset == 0): state IDLE, timer 0, mole 0, hit 0, miss 0, score 0, misses 0, active 0. Reset mid-round abandons the round with no hit/miss pulse.
- IDLE: mole 0. enable == 1 -> GAP, timer <= gap_time.
- GAP: mole 0. timer != 0 -> timer decrements. timer == 0:
  - rn < N_MOLES -> SHOW, mole <= 1 << rn, timer <= on_time.
  - rn >= N_MOLES -> stay in GAP, timer stays 0, rn resampled next cycle (no modulo bias).
- SHOW, evaluated in priority order:
  - (btn & mole) != 0 -> hit pulse, score + 1 (saturating at all-ones), mole <= 0, GAP, timer <= gap_time. A hit wins over a same-cycle timeout.
  - timer == 0 -> miss pulse, misses + 1 (saturating), mole <= 0, GAP, timer <= gap_time.
  - else timer decrements. Wrong-button presses (btn != 0, btn & mole == 0) are ignored.
  - Multiple buttons including the lit mole count as one hit.
- enable == 0 in any state -> IDLE next edge, mole 0, no hit/miss generated. Counters hold.
- clear: score <= 0, misses <= 0. It takes priority over a same-cycle increment, so the result is 0. clear works in every state.
- on_time/gap_time are sampled only at timer load; changes mid-phase take effect at the next phase.
- hit/miss are never high together and never high for two consecutive cycles.

## Timing

- All outputs are registered. No combinational path from input to output.
- Enable sampled high at edge E0 -> GAP at E0. With valid rn, mole lights at edge E0 + gap_time + 1.
- Mole lit at edge L. With no press, miss pulses and mole clears at edge L + on_time + 1. The mole is lit for exactly on_time + 1 cycles.
- Correct btn sampled at edge T -> hit = 1, score updated, mole = 0, all at edge T. Visible the cycle after btn is asserted.
- After a hit or miss at edge T, the next mole lights at edge T + gap_time + 1 at the earliest.
- on_time = 0: mole is lit for 1 cycle. gap_time = 0: 1 dark cycle minimum between moles.
- Score at all-ones plus a hit -> score stays all-ones, hit still pulses.

## Test plan

- Reset, enable = 1, gap_time = 3, on_time = 5, rn = 2, no buttons -> mole = 4'b0100 at edge 4; miss pulse, mole = 0, misses = 1 at edge 10.
- Mole 2 lit, btn = 4'b0100 on the second lit cycle -> next edge hit = 1, score = 1, mole = 0; next mole after gap_time + 1 edges.
- N_MOLES = 3, IDX_W = 2, rn held at 3 for 4 cycles then 1 -> GAP extends 4 cycles, then mole = 3'b010.
- Mole lit, btn = 4'b0001 (wrong) then timeout -> no hit, score unchanged, miss = 1, misses = 1. Also: correct btn in the timeout cycle -> hit only.
- SCORE_W = 2, 5 consecutive hits -> score 1, 2, 3, 3, 3 with 5 hit pulses; clear asserted together with a hit -> score = 0.
- Mid-SHOW enable = 0 -> IDLE, mole = 0 next edge, no pulse. Mid-SHOW reset = 0 -> all outputs 0 immediately (async), score = 0.
